sram_port_arbiter: RTL and testbench

- Shares the single SRAM controller port between two masters: m0 = data cache controller (line fills, write-through), m1 = instruction fetch / second memory client.
- Round-robin grant with a per-master lock, so a two-word cache fill completes atomically.
- A hold limit bounds starvation.
- Sits between the masters and the SRAM controller; the grant and hold counter are the sequential state.

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/arb_rr2.sv | 24 ++
 rtl/sram_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM port arbiter.
package sram_arb_pkg;

  localparam int unsigned HOLD_W = 4;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick; optionally masks the releasing master so a
// release cycle can hand the port straight to the other requester.
module arb_rr2
  import sram_arb_pkg::*;
(
  input  logic r0,
  input  logic r1,
  input  logic ptr,
  input  logic mask_self,
  input  logic self,
  output logic valid,
  output logic winner
);

  logic eff0;
  logic eff1;

  assign eff0   = r0 & ~(mask_self & (self == M0));
  assign eff1   = r1 & ~(mask_self & (self == M1));
  assign valid  = eff0 | eff1;
  // On a tie the master that did not own the port last wins.
  assign winner = (eff0 & eff1) ? ~ptr : eff1;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between two masters: round-robin grant,
// per-master lock for atomic multi-word bursts, hold limit against starvation.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic              m0_lock,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic              m1_lock,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_read,
  output logic              sram_write,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  localparam int unsigned CNT_W = HOLD_W + 1;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              last_grant;
  logic              last_grant_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;

  logic req0;
  logic req1;
  logic own;
  logic req_own;
  logic req_other;
  logic lock_own;
  logic hold_ok;
  logic release_own;
  logic arb_ptr;
  logic arb_mask;
  logic arb_valid;
  logic arb_winner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign own       = (state == GRANT1) ? M1 : M0;
  assign req_own   = own ? req1 : req0;
  assign req_other = own ? req0 : req1;
  assign lock_own  = own ? m1_lock : m0_lock;
  assign hold_ok   = (CNT_W'(hold_cnt) + CNT_W'(1)) < CNT_W'(MAX_HOLD);

  // One arbiter serves both the idle pick and the release-time handover.
  assign arb_ptr  = (state == IDLE) ? last_grant : own;
  assign arb_mask = (state != IDLE);

  arb_rr2 u_arb (
    .r0        (req0),
    .r1        (req1),
    .ptr       (arb_ptr),
    .mask_self (arb_mask),
    .self      (own),
    .valid     (arb_valid),
    .winner    (arb_winner)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= M1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      hold_cnt   <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    hold_cnt_nxt   = hold_cnt;
    release_own    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) state_nxt = arb_winner ? GRANT1 : GRANT0;
      end
      GRANT0, GRANT1: begin
        if (sram_ready) begin
          if (lock_own && (!req_other || hold_ok)) begin
            hold_cnt_nxt = (hold_cnt == '1) ? hold_cnt : hold_cnt + HOLD_W'(1);
          end else begin
            release_own = 1'b1;
          end
        end else if (!req_own && !lock_own) begin
          // A locked master keeps the port even while it has nothing to issue.
          release_own = 1'b1;
        end
        if (release_own) begin
          last_grant_nxt = own;
          hold_cnt_nxt   = '0;
          state_nxt      = arb_valid ? (arb_winner ? GRANT1 : GRANT0) : IDLE;
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Route the owning master to the SRAM port; the other one is fully masked.
  always_comb begin
    sram_address = '0;
    sram_wdata   = '0;
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    m0_ready     = 1'b0;
    m1_ready     = 1'b0;
    case (state)
      GRANT0: begin
        sram_address = m0_address;
        sram_wdata   = m0_wdata;
        sram_write   = m0_write;
        sram_read    = m0_read & ~m0_write;
        m0_ready     = sram_ready;
      end
      GRANT1: begin
        sram_address = m1_address;
        sram_wdata   = m1_wdata;
        sram_write   = m1_write;
        sram_read    = m1_read & ~m1_write;
        m1_ready     = sram_ready;
      end
      default: ;
    endcase
  end

  assign m0_rdata = sram_rdata;
  assign m1_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with hand-computed expectations.
module tb_sram_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_G0   = 32'd1;
  localparam logic [31:0] S_G1   = 32'd2;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] m0_address, m1_address, sram_address;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, sram_wdata;
  logic              m0_read, m0_write, m0_lock;
  logic              m1_read, m1_write, m1_lock;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, sram_rdata;
  logic              m0_ready, m1_ready;
  logic              sram_read, sram_write, sram_ready;

  int n_tests = 0;
  int n_fail  = 0;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_address   (m0_address),
    .m0_wdata     (m0_wdata),
    .m0_read      (m0_read),
    .m0_write     (m0_write),
    .m0_lock      (m0_lock),
    .m0_rdata     (m0_rdata),
    .m0_ready     (m0_ready),
    .m1_address   (m1_address),
    .m1_wdata     (m1_wdata),
    .m1_read      (m1_read),
    .m1_write     (m1_write),
    .m1_lock      (m1_lock),
    .m1_rdata     (m1_rdata),
    .m1_ready     (m1_ready),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_read    (sram_read),
    .sram_write   (sram_write),
    .sram_rdata   (sram_rdata),
    .sram_ready   (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = '0; m0_wdata = '0;
    m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = '0; m1_wdata = '0;
    sram_ready = 0; sram_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    do_reset();
    settle();
    check("rst_state", 32'(dut.state), S_IDLE);
    check("rst_hold", 32'(dut.hold_cnt), 32'd0);
    check("rst_sram_read", 32'(sram_read), 32'd0);
    check("rst_sram_addr", sram_address, 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);

    // Single m0 read.
    m0_read = 1; m0_address = 32'h100;
    settle();
    check("t1_latency_read", 32'(sram_read), 32'd0);
    tick();
    check("t1_state_g0", 32'(dut.state), S_G0);
    check("t1_sram_read", 32'(sram_read), 32'd1);
    check("t1_sram_addr", sram_address, 32'h100);
    tick();
    tick();
    check("t1_wait_ready", 32'(m0_ready), 32'd0);
    sram_ready = 1; sram_rdata = 32'hDEADBEEF;
    settle();
    check("t1_m0_ready", 32'(m0_ready), 32'd1);
    check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_ready", 32'(m1_ready), 32'd0);
    tick();
    m0_read = 0; sram_ready = 0;
    settle();
    check("t1_back_idle", 32'(dut.state), S_IDLE);
    check("t1_ready_drop", 32'(m0_ready), 32'd0);

    // Simultaneous reads after reset: m0 first, m1 with no bubble.
    do_reset();
    m0_read = 1; m0_address = 32'h100;
    m1_read = 1; m1_address = 32'h200;
    tick();
    check("t2_first_g0", 32'(dut.state), S_G0);
    check("t2_addr_m0", sram_address, 32'h100);
    sram_ready = 1;
    settle();
    check("t2_m0_ready", 32'(m0_ready), 32'd1);
    check("t2_m1_masked", 32'(m1_ready), 32'd0);
    tick();
    m0_read = 0; sram_ready = 0;
    settle();
    check("t2_g1_nobubble", 32'(dut.state), S_G1);
    check("t2_addr_m1", sram_address, 32'h200);
    check("t2_read_m1", 32'(sram_read), 32'd1);
    sram_ready = 1;
    settle();
    check("t2_m1_ready", 32'(m1_ready), 32'd1);
    check("t2_m0_masked", 32'(m0_ready), 32'd0);
    tick();
    m1_read = 0; sram_ready = 0;
    settle();
    check("t2_idle", 32'(dut.state), S_IDLE);

    // Locked two-word fill by m0 while m1 waits.
    m0_read = 1; m0_lock = 1; m0_address = 32'h108;
    m1_read = 1; m1_address = 32'h200;
    tick();
    check("t3_g0", 32'(dut.state), S_G0);
    check("t3_addr_w0", sram_address, 32'h108);
    sram_ready = 1;
    settle();
    check("t3_ready_w0", 32'(m0_ready), 32'd1);
    tick();
    sram_ready = 0; m0_lock = 0; m0_address = 32'h10C;
    settle();
    check("t3_still_g0", 32'(dut.state), S_G0);
    check("t3_addr_w1", sram_address, 32'h10C);
    check("t3_hold1", 32'(dut.hold_cnt), 32'd1);
    sram_ready = 1;
    settle();
    check("t3_ready_w1", 32'(m0_ready), 32'd1);
    tick();
    m0_read = 0; sram_ready = 0;
    settle();
    check("t3_to_g1", 32'(dut.state), S_G1);
    check("t3_addr_m1", sram_address, 32'h200);
    check("t3_hold_clr", 32'(dut.hold_cnt), 32'd0);
    sram_ready = 1;
    tick();
    m1_read = 0; sram_ready = 0;
    settle();
    check("t3_idle", 32'(dut.state), S_IDLE);

    // Hold limit: m0 locked forever, m1 requesting.
    m0_read = 1; m0_lock = 1; m0_address = 32'h140;
    m1_read = 1; m1_address = 32'h240;
    tick();
    check("t4_g0", 32'(dut.state), S_G0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_state_%0d", i), 32'(dut.state), S_G0);
      check($sformatf("t4_hold_%0d", i), 32'(dut.hold_cnt), 32'(i));
      sram_ready = 1;
      settle();
      check($sformatf("t4_ready_%0d", i), 32'(m0_ready), 32'd1);
      tick();
      sram_ready = 0;
      settle();
    end
    check("t4_forced_g1", 32'(dut.state), S_G1);
    check("t4_hold_clr", 32'(dut.hold_cnt), 32'd0);
    check("t4_addr_m1", sram_address, 32'h240);
    m0_read = 0; m0_lock = 0;
    sram_ready = 1;
    tick();
    m1_read = 0; sram_ready = 0;
    settle();
    check("t4_idle", 32'(dut.state), S_IDLE);

    // Write wins over read.
    m1_read = 1; m1_write = 1; m1_address = 32'h300; m1_wdata = 32'h55AA55AA;
    tick();
    check("t5_g1", 32'(dut.state), S_G1);
    check("t5_write", 32'(sram_write), 32'd1);
    check("t5_read", 32'(sram_read), 32'd0);
    check("t5_wdata", sram_wdata, 32'h55AA55AA);
    sram_ready = 1;
    tick();
    m1_read = 0; m1_write = 0; sram_ready = 0;
    settle();
    check("t5_idle", 32'(dut.state), S_IDLE);

    // Reset while GRANT1 waits on the SRAM.
    m1_read = 1; m1_address = 32'h400;
    tick();
    check("t6_g1", 32'(dut.state), S_G1);
    tick();
    rst = 1'b0;
    tick();
    check("t6_rst_idle", 32'(dut.state), S_IDLE);
    check("t6_rst_read", 32'(sram_read), 32'd0);
    check("t6_rst_write", 32'(sram_write), 32'd0);
    rst = 1'b1;
    m0_read = 1; m0_address = 32'h500;
    settle();
    check("t6_idle_before", 32'(dut.state), S_IDLE);
    tick();
    check("t6_tie_m0", 32'(dut.state), S_G0);
    check("t6_addr_m0", sram_address, 32'h500);
    check("t6_m1_no_ready", 32'(m1_ready), 32'd0);

    idle_inputs();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
